// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param
// Brief    : Parametrised single-clock FIFO with occupancy count,
//            programmable almost-full/almost-empty flags, sticky overflow and
//            underflow errors, and optional first-word-fall-through reads.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_param #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [DW-1:0] Din,
    input  logic          Wen,
    input  logic          Ren,
    input  logic          Eclr,
    output logic [DW-1:0] Dout,
    output logic          Dvalid,
    output logic          Fempty,
    output logic          Ffull,
    output logic          Falmost_empty,
    output logic          Falmost_full,
    output logic [AW:0]   Count,
    output logic          Ovf,
    output logic          Udf
);

    localparam int          C_DEPTH_I = 2 ** AW;
    localparam logic [AW:0] C_DEPTH   = (AW + 1)'(C_DEPTH_I);
    localparam logic [AW:0] C_AF_LVL  = (AW + 1)'(AF_LVL);
    localparam logic [AW:0] C_AE_LVL  = (AW + 1)'(AE_LVL);
    localparam logic [AW:0] C_CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    // Storage is deliberately not reset; stale contents are unreachable
    // because the pointers and count restart from zero.
    logic [DW-1:0] mem_q [C_DEPTH_I];

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          fempty_q;
    logic          ffull_q;
    logic          aempty_q;
    logic          afull_q;
    logic          ovf_q;
    logic          udf_q;

    // Acceptance is decided on the registered flags only, so a full FIFO
    // never writes through and an empty FIFO never bypasses.
    logic w_wr_ok;
    logic w_rd_ok;
    assign w_wr_ok = Wen & ~ffull_q;
    assign w_rd_ok = Ren & ~fempty_q;

    // Next occupancy: the single source from which every flag is derived.
    always_comb begin
        count_d = count_q;
        if (w_wr_ok && !w_rd_ok) begin
            count_d = count_q + C_CNT_ONE;
        end else if (!w_wr_ok && w_rd_ok) begin
            count_d = count_q - C_CNT_ONE;
        end
    end

    // Pointers, count, status flags and sticky errors.
    always_ff @(posedge ck) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            fempty_q <= 1'b1;
            ffull_q  <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                wptr_q <= wptr_q + C_PTR_ONE;
            end
            if (w_rd_ok) begin
                rptr_q <= rptr_q + C_PTR_ONE;
            end
            count_q  <= count_d;
            fempty_q <= (count_d == '0);
            ffull_q  <= (count_d == C_DEPTH);
            aempty_q <= (count_d <= C_AE_LVL);
            afull_q  <= (count_d >= C_AF_LVL);
            // A new error in the same cycle as Eclr takes priority.
            ovf_q    <= (Wen & ffull_q)  | (ovf_q & ~Eclr);
            udf_q    <= (Ren & fempty_q) | (udf_q & ~Eclr);
        end
    end

    // Data storage; writes are suppressed while reset is asserted.
    always_ff @(posedge ck) begin
        if (rst && w_wr_ok) begin
            mem_q[wptr_q] <= Din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is always presented; valid whenever not empty.
            assign Dout   = mem_q[rptr_q];
            assign Dvalid = ~fempty_q;
        end else begin : g_reg_read
            logic [DW-1:0] dout_q;
            logic          dvalid_q;

            // Registered read: data and a one-cycle valid pulse per pop.
            always_ff @(posedge ck) begin
                if (!rst) begin
                    dout_q   <= '0;
                    dvalid_q <= 1'b0;
                end else begin
                    dvalid_q <= w_rd_ok;
                    if (w_rd_ok) begin
                        dout_q <= mem_q[rptr_q];
                    end
                end
            end

            assign Dout   = dout_q;
            assign Dvalid = dvalid_q;
        end
    endgenerate

    assign Count         = count_q;
    assign Fempty        = fempty_q;
    assign Ffull         = ffull_q;
    assign Falmost_empty = aempty_q;
    assign Falmost_full  = afull_q;
    assign Ovf           = ovf_q;
    assign Udf           = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_param
// Brief    : Self-checking bench for fifo_param. Two instances (registered
//            read and FWFT) share one stimulus stream and are compared with a
//            queue-based reference model, a directed vector table and
//            hand-written corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    logic       ck = 1'b0;
    logic       rst;
    logic [7:0] Din;
    logic       Wen;
    logic       Ren;
    logic       Eclr;

    logic [7:0] d0_dout, d1_dout;
    logic       d0_dv, d1_dv, d0_fe, d1_fe, d0_ff, d1_ff;
    logic       d0_ae, d1_ae, d0_af, d1_af, d0_ovf, d1_ovf, d0_udf, d1_udf;
    logic [4:0] d0_cnt, d1_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 ck = ~ck;

    fifo_param #(.DW(8), .AW(4), .AF_LVL(12), .AE_LVL(2), .FWFT(0)) u_dut0 (
        .ck(ck), .rst(rst), .Din(Din), .Wen(Wen), .Ren(Ren), .Eclr(Eclr),
        .Dout(d0_dout), .Dvalid(d0_dv), .Fempty(d0_fe), .Ffull(d0_ff),
        .Falmost_empty(d0_ae), .Falmost_full(d0_af), .Count(d0_cnt),
        .Ovf(d0_ovf), .Udf(d0_udf)
    );

    fifo_param #(.DW(8), .AW(4), .AF_LVL(12), .AE_LVL(2), .FWFT(1)) u_dut1 (
        .ck(ck), .rst(rst), .Din(Din), .Wen(Wen), .Ren(Ren), .Eclr(Eclr),
        .Dout(d1_dout), .Dvalid(d1_dv), .Fempty(d1_fe), .Ffull(d1_ff),
        .Falmost_empty(d1_ae), .Falmost_full(d1_af), .Count(d1_cnt),
        .Ovf(d1_ovf), .Udf(d1_udf)
    );

    // ---------------- reference model (queue of stored words) -------------
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       m_dv0 = 1'b0;
    logic [7:0] m_dout0 = 8'h00;

    task automatic model_update(input logic rn, w, r, e, input logic [7:0] d);
        bit was_full, was_empty;
        if (!rn) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_dv0   = 1'b0;
            m_dout0 = 8'h00;
        end else begin
            was_full  = (m_q.size() == 16);
            was_empty = (m_q.size() == 0);
            m_ovf = (w && was_full)  || (m_ovf && !e);
            m_udf = (r && was_empty) || (m_udf && !e);
            if (r && !was_empty) begin
                m_dout0 = m_q.pop_front();
                m_dv0   = 1'b1;
            end else begin
                m_dv0   = 1'b0;
            end
            if (w && !was_full) m_q.push_back(d);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, sample at +1.
    task automatic step(input logic rn, w, r, e, input logic [7:0] d);
        @(negedge ck);
        rst = rn; Wen = w; Ren = r; Eclr = e; Din = d;
        @(posedge ck);
        model_update(rn, w, r, e, d);
        #1;
    endtask

    task automatic compare_all(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, " cnt0"},  32'(d0_cnt), 32'(sz));
        chk({tag, " cnt1"},  32'(d1_cnt), 32'(sz));
        chk({tag, " fe"},    32'(d0_fe),  32'(sz == 0));
        chk({tag, " ff"},    32'(d0_ff),  32'(sz == 16));
        chk({tag, " ae"},    32'(d0_ae),  32'(sz <= 2));
        chk({tag, " af"},    32'(d0_af),  32'(sz >= 12));
        chk({tag, " ovf"},   32'(d0_ovf), 32'(m_ovf));
        chk({tag, " udf"},   32'(d0_udf), 32'(m_udf));
        chk({tag, " dv0"},   32'(d0_dv),  32'(m_dv0));
        chk({tag, " dout0"}, 32'(d0_dout), 32'(m_dout0));
        chk({tag, " dv1"},   32'(d1_dv),  32'(sz != 0));
        if (sz != 0) chk({tag, " dout1"}, 32'(d1_dout), 32'(m_q[0]));
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic       rn, w, r, e;
        logic [7:0] d;
        int         cnt;
        logic       fe, ff, ovf, udf, dv;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[14];

    initial begin
        rst = 1'b0; Wen = 1'b0; Ren = 1'b0; Eclr = 1'b0; Din = 8'h00;

        //         rn    w     r     e     din    cnt fe    ff    ovf   udf   dv    dout
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rn, tbl[i].w, tbl[i].r, tbl[i].e, tbl[i].d);
            chk($sformatf("tbl%0d cnt", i),  32'(d0_cnt),  32'(tbl[i].cnt));
            chk($sformatf("tbl%0d fe", i),   32'(d0_fe),   32'(tbl[i].fe));
            chk($sformatf("tbl%0d ff", i),   32'(d0_ff),   32'(tbl[i].ff));
            chk($sformatf("tbl%0d ae", i),   32'(d0_ae),   32'(tbl[i].cnt <= 2));
            chk($sformatf("tbl%0d af", i),   32'(d0_af),   32'(tbl[i].cnt >= 12));
            chk($sformatf("tbl%0d ovf", i),  32'(d0_ovf),  32'(tbl[i].ovf));
            chk($sformatf("tbl%0d udf", i),  32'(d0_udf),  32'(tbl[i].udf));
            chk($sformatf("tbl%0d dv", i),   32'(d0_dv),   32'(tbl[i].dv));
            chk($sformatf("tbl%0d dout", i), 32'(d0_dout), 32'(tbl[i].dout));
            chk($sformatf("tbl%0d dv1", i),  32'(d1_dv),   32'(!tbl[i].fe));
        end

        // ---------------- reset then fill ----------------------------------
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        compare_all("rst");
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
            compare_all($sformatf("fill%0d", i));
            chk($sformatf("fill%0d af", i), 32'(d0_af), 32'(i + 1 >= 12));
        end
        chk("full flag", 32'(d0_ff), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        compare_all("wr17");
        chk("wr17 ovf", 32'(d0_ovf), 32'd1);
        chk("wr17 cnt", 32'(d0_cnt), 32'd16);

        // ---------------- drain ---------------------------------------------
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            compare_all($sformatf("drain%0d", i));
            chk($sformatf("drain%0d data", i), 32'(d0_dout), 32'(i));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("drain dv drop", 32'(d0_dv), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        compare_all("rd_extra");
        chk("rd_extra udf", 32'(d0_udf), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        compare_all("eclr");
        chk("eclr ovf", 32'(d0_ovf), 32'd0);
        chk("eclr udf", 32'(d0_udf), 32'd0);

        // ---------------- simultaneous ops at count 5 ----------------------
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h90 + i));
            compare_all($sformatf("simul%0d", i));
            chk($sformatf("simul%0d cnt", i), 32'(d0_cnt), 32'd5);
        end

        // ---------------- full with Wen=Ren=1 -------------------------------
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        compare_all("refill");
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        compare_all("full_wr_rd");
        chk("full_wr_rd cnt", 32'(d0_cnt), 32'd15);
        chk("full_wr_rd ovf", 32'(d0_ovf), 32'd1);

        // ---------------- empty with Wen=Ren=1 ------------------------------
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        compare_all("emptied");
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A);
        compare_all("empty_wr_rd");
        chk("empty_wr_rd cnt", 32'(d0_cnt), 32'd1);
        chk("empty_wr_rd udf", 32'(d0_udf), 32'd1);
        chk("empty_wr_rd dv",  32'(d0_dv),  32'd0);

        // ---------------- FWFT single word ----------------------------------
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        chk("fwft dout", 32'(d1_dout), 32'hA5);
        chk("fwft dv",   32'(d1_dv),   32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft pop fe", 32'(d1_fe), 32'd1);
        chk("fwft pop dv", 32'(d1_dv), 32'd0);
        compare_all("fwft");

        // ---------------- mid-operation reset -------------------------------
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        chk("pre_rst cnt", 32'(d0_cnt), 32'd7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("midrst cnt", 32'(d0_cnt), 32'd0);
        chk("midrst fe",  32'(d0_fe),  32'd1);
        chk("midrst dv0", 32'(d0_dv),  32'd0);
        chk("midrst dv1", 32'(d1_dv),  32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        chk("postrst head", 32'(d1_dout), 32'h77);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("postrst data", 32'(d0_dout), 32'h77);
        compare_all("postrst");

        // ---------------- randomized against the model ----------------------
        for (int i = 0; i < 800; i++) begin
            int wp, rp;
            wp = ((i / 100) % 2 == 0) ? 75 : 30;
            rp = ((i / 100) % 2 == 0) ? 30 : 75;
            step(($urandom_range(0, 79) != 0),
                 ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < rp),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom));
            compare_all($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO. It is the next-generation replacement for the team's fixed 8x16 FIFO.
- Generalised in data width and depth (power of two).
- New over the fixed FIFO:
  - read and write accepted in the same cycle;
  - occupancy count output;
  - programmable almost-full and almost-empty flags;
  - sticky overflow/underflow error flags;
  - optional first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer blocks as the standard elastic buffer.

Parameters:
- DW, 8, data width in bits.
- AW, 4, address width; depth DEPTH = 2**AW entries.
- AF_LVL, 12, Falmost_full asserts when count >= AF_LVL (1..DEPTH).
- AE_LVL, 2, Falmost_empty asserts when count <= AE_LVL (0..DEPTH-1).
- FWFT, 0, 0 = registered read (data one cycle after Ren); 1 = first-word-fall-through.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- Din  in  DW  write data.
- Wen  in  1  write request.
- Ren  in  1  read request (pop).
- Eclr  in  1  clears sticky Ovf/Udf.
- Dout  out  DW  read data.
- Dvalid  out  1  Dout holds valid read data.
- Fempty  out  1  FIFO empty.
- Ffull  out  1  FIFO full.
- Falmost_empty  out  1  count <= AE_LVL.
- Falmost_full  out  1  count >= AF_LVL.
- Count  out  AW+1  current occupancy, 0..DEPTH.
- Ovf  out  1  sticky: a write was attempted while full.
- Udf  out  1  sticky: a read was attempted while empty.

Behaviour:
- All state updates on posedge ck. rst=0 at an edge overrides every other input.
- Reset values:
  - Wptr, Rptr, Count = 0.
  - Fempty = 1, Ffull = 0, Falmost_empty = 1, Falmost_full = 0.
  - Ovf = 0, Udf = 0.
  - Dout = 0, Dvalid = 0.
- Memory contents are not reset.
- Reset mid-operation discards all stored data. The next cycle behaves as freshly reset.
- Acceptance rules:
  - wr_ok = Wen & !Ffull.
  - rd_ok = Ren & !Fempty.
  - Both are evaluated on the registered flags at the start of the cycle.
- Simultaneous wr_ok & rd_ok: both performed, both pointers advance, Count unchanged, flags unchanged.
- Full with Wen & Ren: read accepted, write rejected. Ovf is set and Count decrements. No write-through.
- Empty with Wen & Ren: write accepted, read rejected. Udf is set. No bypass.
- Pointers are AW bits and wrap modulo DEPTH. Count is AW+1 bits and is the single source for all flags.
- Count_next:
  - +1 on write only;
  - -1 on read only;
  - unchanged otherwise.
- Flags are registered from Count_next:
  - Fempty = (Count_next == 0);
  - Ffull = (Count_next == DEPTH);
  - Falmost_empty = (Count_next <= AE_LVL);
  - Falmost_full = (Count_next >= AF_LVL).
- Write-to-not-empty latency is 1 cycle: Fempty falls at the same edge that stores the word.
- Ovf is set by Wen & Ffull; Udf is set by Ren & Fempty. Both hold until Eclr=1 or reset.
- If Eclr and a new error occur in the same cycle, the set wins.
- FWFT=0 mode:
  - On rd_ok, Dout <= MEM[Rptr] at that edge and Dvalid = 1 for exactly that following cycle.
  - Otherwise Dvalid = 0 and Dout holds its last value.
- FWFT=1 mode:
  - Dout = MEM[Rptr] continuously (head entry), and Dvalid = !Fempty.
  - Ren pops the head; the next entry is visible the cycle after the pop.
  - Dout is don't-care while Fempty = 1.
- No data reordering or loss for accepted operations. Rejected operations change no data state.

Test Plan:
- Reset then fill: hold rst=0 for 2 cycles, release, write 0x00..0x0F on consecutive cycles.
  - Count steps 1..16, Falmost_full rises at the edge where Count becomes 12, Ffull=1 after the 16th write.
  - A 17th Wen sets Ovf=1 and leaves Count=16.
- Drain (FWFT=0): from full, hold Ren for 16 cycles.
  - Dout = 0x00..0x0F, each with a one-cycle Dvalid pulse, one cycle after each accepted Ren.
  - Falmost_empty rises when Count becomes 2. Fempty=1 after the last read.
  - An extra Ren sets Udf=1.
- Simultaneous ops: with Count=5, hold Wen=Ren=1 for 20 cycles with incrementing Din.
  - Count stays 5, pointers wrap past 15 to 0.
  - Read data order exactly matches write order.
- Boundary cases:
  - Full plus Wen=Ren=1 gives Count 16->15 and Ovf=1.
  - Empty plus Wen=Ren=1 gives Count 0->1, Udf=1, and Dvalid stays 0.
- FWFT=1: write 0xA5 into an empty FIFO.
  - The next cycle shows Dout=0xA5 with Dvalid=1.
  - Ren pops it: Fempty=1 and Dvalid=0 the following cycle.
- Eclr and mid-operation reset:
  - Eclr=1 clears Ovf/Udf.
  - Asserting rst at Count=7 gives Count=0, Fempty=1 and Dvalid=0 next cycle. Old data is never read back.
